regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_clear_fsm.sv | 67 ++++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the multi-port register file.
//   clr_state_e : clear-sequencer state encoding (IDLE=0, CLEAR=1)
//   *_DEF       : default parameter values used by regfile_mp
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm -- sequencer that walks every register once to zero it.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_req      : start a clear (sampled only in IDLE)
//   state_o      : current sequencer state (also used as debug view)
//   ptr_o        : register index being cleared this cycle
//   clr_busy     : high while in CLEAR
//   clr_done     : one-cycle pulse in the cycle after CLEAR ends
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output clr_state_e        state_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              clr_busy,
  output logic              clr_done
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        // Last register is zeroed on this edge; done pulses the cycle after.
        if (ptr_q == '1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o  = state_q;
  assign ptr_o    = ptr_q;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port register file with write-back bypass,
// per-register pending scoreboard and a sequential whole-file clear.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   rd_addr / rd_data     : NUM_RD packed read ports, port k at [k*W +: W]
//   rd_pending            : per-port flag, addressed register awaits write-back
//   wr_en/wr_addr/wr_data : write-back port
//   issue_en/issue_addr   : mark a register pending
//   clr_req               : start sequential clear
//   clr_busy / clr_done   : clear in progress / one-cycle completion pulse
// Strobe semantics: wr_en, issue_en and clr_req are single-cycle strobes with
// no back-pressure; each is acted on at the rising edge where it is high while
// the file is IDLE, and silently dropped while clr_busy is high.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;

  clr_state_e        clr_state;
  logic [ADDR_W-1:0] clr_ptr;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .state_o  (clr_state),
    .ptr_o    (clr_ptr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  logic idle;
  logic clr_start;
  logic wr_to_zero;
  logic wr_ok;

  assign idle       = (clr_state == ST_IDLE);
  assign clr_start  = idle & clr_req;
  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_ok      = wr_en & idle & ~wr_to_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q     <= '{default: '0};
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
    if (!idle) begin
      mem_d[clr_ptr] = '0;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (idle) begin
      // Clear first, then set: a same-edge issue to the same register wins.
      if (wr_en) begin
        pending_d[wr_addr] = 1'b0;
      end
      if (issue_en) begin
        pending_d[issue_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
        pending_d[0] = 1'b0;
      end
      // Entering CLEAR wipes the whole scoreboard.
      if (clr_start) begin
        pending_d = '0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              bypass;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign bypass = wr_en & idle & (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] =
      ((ZERO_REG != 0) && (addr == '0)) ? '0 :
      bypass                             ? wr_data :
                                           mem_q[addr];

    // A same-cycle write-back already supplies the value, so it is not pending.
    assign rd_pending[k] = idle & pending_q[addr] & ~bypass;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    clr_req    = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rd0();
    return rd_data[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rd1();
    return rd_data[2*DATA_W-1:DATA_W];
  endfunction

  int busy_cnt;
  int done_cnt;
  int zero_bad;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    set_rd(5'd5, 5'd31);
    tick();
    tick();

    // reset state
    check("rst_busy",    {31'd0, clr_busy}, 32'd0);
    check("rst_done",    {31'd0, clr_done}, 32'd0);
    check("rst_rd0",     rd0(), 32'd0);
    check("rst_rd1",     rd1(), 32'd0);
    check("rst_pending", {30'd0, rd_pending}, 32'd0);
    reset_n = 1'b1;
    tick();

    // write then read
    write_reg(5'd5, 32'hDEAD_BEEF);
    set_rd(5'd5, 5'd6);
    settle();
    check("wr_rd_data",    rd0(), 32'hDEAD_BEEF);
    check("wr_rd_pending", {31'd0, rd_pending[0]}, 32'd0);
    check("wr_rd_other",   rd1(), 32'd0);

    // same-cycle bypass on port 1
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h0000_1234;
    set_rd(5'd5, 5'd7);
    settle();
    check("bypass_rd1",   rd1(), 32'h0000_1234);
    check("bypass_rd0",   rd0(), 32'hDEAD_BEEF);
    tick();
    wr_en = 1'b0;
    settle();
    check("bypass_stored", rd1(), 32'h0000_1234);

    // zero register: write and issue to r0
    wr_en      = 1'b1;
    wr_addr    = 5'd0;
    wr_data    = 32'hFFFF_FFFF;
    issue_en   = 1'b1;
    issue_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    settle();
    check("zero_nobypass", rd0(), 32'd0);
    tick();
    idle_inputs();
    settle();
    check("zero_data",    rd0(), 32'd0);
    check("zero_pending", {31'd0, rd_pending[0]}, 32'd0);

    // scoreboard
    issue_en   = 1'b1;
    issue_addr = 5'd3;
    set_rd(5'd4, 5'd3);
    tick();
    issue_en = 1'b0;
    settle();
    check("sb_issue",       {31'd0, rd_pending[1]}, 32'd1);
    check("sb_other_port",  {31'd0, rd_pending[0]}, 32'd0);
    issue_en   = 1'b1;
    issue_addr = 5'd3;
    wr_en      = 1'b1;
    wr_addr    = 5'd3;
    wr_data    = 32'h0000_00A5;
    settle();
    check("sb_byp_pending", {31'd0, rd_pending[1]}, 32'd0);
    check("sb_byp_data",    rd1(), 32'h0000_00A5);
    tick();
    idle_inputs();
    settle();
    check("sb_issue_wins",  {31'd0, rd_pending[1]}, 32'd1);
    check("sb_data",        rd1(), 32'h0000_00A5);
    write_reg(5'd3, 32'h0000_005A);
    settle();
    check("sb_cleared",     {31'd0, rd_pending[1]}, 32'd0);
    check("sb_data2",       rd1(), 32'h0000_005A);

    // full clear
    for (int i = 1; i < 32; i++) begin
      write_reg(i[ADDR_W-1:0], 32'h1000_0000 | i);
    end
    set_rd(5'd1, 5'd31);
    settle();
    check("fill_r1",  rd0(), 32'h1000_0001);
    check("fill_r31", rd1(), 32'h1000_001F);
    issue_en   = 1'b1;
    issue_addr = 5'd9;
    tick();
    issue_en = 1'b0;
    set_rd(5'd9, 5'd31);
    settle();
    check("pre_clr_pending", {31'd0, rd_pending[0]}, 32'd1);

    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    while (clr_busy && busy_cnt < 100) begin
      if (busy_cnt == 0) begin
        // everything driven here must be ignored
        wr_en      = 1'b1;
        wr_addr    = 5'd31;
        wr_data    = 32'h0000_0777;
        issue_en   = 1'b1;
        issue_addr = 5'd6;
        clr_req    = 1'b1;
        set_rd(5'd9, 5'd31);
        settle();
        check("clr_no_bypass",  rd1(), 32'h1000_001F);
        check("clr_pending0",   {30'd0, rd_pending}, 32'd0);
        check("clr_done_early", {31'd0, clr_done}, 32'd0);
      end
      if (busy_cnt == 5) begin
        set_rd(5'd2, 5'd20);
        settle();
        check("clr_partial_r2",  rd0(), 32'd0);
        check("clr_partial_r20", rd1(), 32'h1000_0014);
      end
      tick();
      if (busy_cnt == 0) idle_inputs();
      busy_cnt++;
    end
    check("clr_busy_cycles", busy_cnt, 32'd32);
    check("clr_done_pulse",  {31'd0, clr_done}, 32'd1);
    tick();
    check("clr_done_single", {31'd0, clr_done}, 32'd0);
    check("clr_busy_after",  {31'd0, clr_busy}, 32'd0);
    zero_bad = 0;
    for (int i = 0; i < 32; i += 2) begin
      set_rd(i[ADDR_W-1:0], 5'(i + 1));
      settle();
      if (rd0() != 0 || rd1() != 0 || rd_pending != 0) zero_bad++;
    end
    check("clr_all_zero", zero_bad, 32'd0);

    // reset in the middle of a clear
    write_reg(5'd1, 32'h1111_1111);
    write_reg(5'd10, 32'hAAAA_0010);
    write_reg(5'd31, 32'h3131_3131);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_clr_busy", {31'd0, clr_busy}, 32'd1);
    set_rd(5'd1, 5'd31);
    settle();
    check("mid_clr_r31", rd1(), 32'h3131_3131);
    reset_n = 1'b0;
    settle();
    check("rst_mid_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_mid_done", {31'd0, clr_done}, 32'd0);
    check("rst_mid_r1",   rd0(), 32'd0);
    check("rst_mid_r31",  rd1(), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (clr_done || clr_busy) done_cnt++;
      tick();
    end
    check("rst_no_done", done_cnt, 32'd0);
    set_rd(5'd10, 5'd31);
    settle();
    check("rst_r10_zero", rd0(), 32'd0);

    // normal operation after reset
    write_reg(5'd10, 32'h0000_CAFE);
    settle();
    check("post_rst_wr", rd0(), 32'h0000_CAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
